// File: rtl/pixel_write_arbiter.sv
// ============================================================================
//  Module      : pixel_write_arbiter
//  Description : Round-robin arbiter sharing one Avalon-MM write master into
//                the VGA pixel buffer between NUM_REQ drawing engines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           avm_address,
    output logic [DATA_W-1:0]           avm_writedata,
    output logic                        avm_write,
    input  logic                        avm_waitrequest,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_hold_cnt;

    logic [ADDR_W-1:0]  w_addr [NUM_REQ];
    logic [DATA_W-1:0]  w_data [NUM_REQ];
    logic               w_reg_free;
    logic               w_own_valid;
    logic               w_handshake;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W:0]      w_scan;
    logic               w_found;
    logic [7:0]         w_hold_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_reg_free  = !avm_write || !avm_waitrequest;
    assign w_own_valid = req_valid[grant_id];
    assign w_handshake = (r_state == ST_OWN) && w_own_valid && w_reg_free;
    assign w_hold_next = r_hold_cnt + 8'd1;
    assign busy        = (r_state == ST_OWN) || avm_write;

    always_comb begin
        req_ready = '0;
        if (w_handshake)
            req_ready[grant_id] = 1'b1;
    end

    // Rotating scan starting just after the last owner; wraps with one subtract.
    always_comb begin
        w_pick  = grant_id;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, grant_id} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(NUM_REQ))
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            grant_id      <= ID_W'(NUM_REQ - 1);
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            // The output word drains on its own, independent of arbitration state.
            if (w_handshake) begin
                avm_address   <= w_addr[grant_id];
                avm_writedata <= w_data[grant_id];
                avm_write     <= 1'b1;
            end else if (avm_write && !avm_waitrequest) begin
                avm_write     <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_id   <= w_pick;
                        r_hold_cnt <= '0;
                        r_state    <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!w_own_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_handshake) begin
                        r_hold_cnt <= w_hold_next;
                        if (req_last[grant_id] || (w_hold_next == 8'(MAX_HOLD)))
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
// ============================================================================
//  Module      : tb_pixel_write_arbiter
//  Description : Directed bench for pixel_write_arbiter with retire scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 8;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic [ADDR_W-1:0]          avm_address;
    logic [DATA_W-1:0]          avm_writedata;
    logic                       avm_write;
    logic                       avm_waitrequest;
    logic [1:0]                 grant_id;
    logic                       busy;

    pixel_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .avm_address    (avm_address),
        .avm_writedata  (avm_writedata),
        .avm_write      (avm_write),
        .avm_waitrequest(avm_waitrequest),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    typedef struct {
        int              id;
        logic [31:0]     addr;
        logic [15:0]     data;
        logic            last;
    } word_t;

    word_t src_q[$];
    word_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [NUM_REQ-1:0] s_ready;
    logic               s_write;
    logic               s_busy;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_data;
    int                 d_first, d_last, d_nready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input int id, input int seq, input bit last);
        word_t w;
        w.id   = id;
        w.addr = 32'h1000_0000 * (id + 1) + 32'(seq * 2);
        w.data = 16'(id * 16'h1111) ^ 16'(seq * 16'h0137);
        w.last = last;
        return w;
    endfunction

    // Offer the oldest pending word of each requester.
    task automatic drive_inputs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bit found = 1'b0;
            foreach (src_q[j]) begin
                if (!found && src_q[j].id == i) begin
                    found = 1'b1;
                    req_valid[i] = 1'b1;
                    req_addr[i*ADDR_W +: ADDR_W] = src_q[j].addr;
                    req_data[i*DATA_W +: DATA_W] = src_q[j].data;
                    req_last[i] = src_q[j].last;
                end
            end
        end
    endtask

    task automatic pop_src(input int id);
        int idx = -1;
        foreach (src_q[j])
            if (idx < 0 && src_q[j].id == id) idx = j;
        if (idx >= 0) src_q.delete(idx);
    endtask

    task automatic push_pkt(input int id, input int first, input int n, input int pkt_len);
        for (int s = first; s < first + n; s++)
            src_q.push_back(mk(id, s, (pkt_len > 0) && ((s + 1) % pkt_len == 0)));
    endtask

    task automatic push_exp(input int id, input int first, input int n);
        for (int s = first; s < first + n; s++)
            exp_q.push_back(mk(id, s, 1'b0));
    endtask

    // One clock: sample on negedge, score retirements, advance requesters after posedge.
    task automatic step();
        word_t e;
        @(negedge clk);
        s_ready = req_ready;
        s_write = avm_write;
        s_busy  = busy;
        s_addr  = avm_address;
        s_data  = avm_writedata;
        if (avm_write && !avm_waitrequest) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 64'(avm_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("retire_addr", 64'(avm_address), 64'(e.addr));
                chk("retire_data", 64'(avm_writedata), 64'(e.data));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (s_ready[i]) pop_src(i);
        drive_inputs();
    endtask

    task automatic drain(input int max_steps, input string tag);
        int n = 0;
        d_first = -1; d_last = -1; d_nready = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || avm_write) && n < max_steps) begin
            step();
            if (s_ready != '0) begin
                if (d_first < 0) d_first = n;
                d_last = n;
                d_nready++;
            end
            n++;
        end
        chk({tag, "_drained"}, 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        avm_waitrequest = 1'b0;
        drive_inputs();
        @(negedge clk);
        chk("rst_write",   64'(avm_write),     64'd0);
        chk("rst_address", 64'(avm_address),   64'd0);
        chk("rst_data",    64'(avm_writedata), 64'd0);
        chk("rst_ready",   64'(req_ready),     64'd0);
        chk("rst_grant",   64'(grant_id),      64'(NUM_REQ - 1));
        chk("rst_busy",    64'(busy),          64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        drive_inputs();

        // Single requester, one packet of three
        do_reset();
        push_pkt(0, 0, 3, 3);
        push_exp(0, 0, 3);
        drive_inputs();
        step();
        chk("t1_idle_ready", 64'(s_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_ready", 64'(s_ready), 64'b0001);
        end
        step();
        chk("t1_exp_empty", 64'(exp_q.size()), 64'd0);
        step();
        chk("t1_write_idle", 64'(s_write), 64'd0);
        chk("t1_busy_idle",  64'(s_busy),  64'd0);

        // Four contenders, packets of two: order 0,1,2,3,0
        do_reset();
        push_pkt(0, 0, 4, 2);
        for (int i = 1; i < NUM_REQ; i++) push_pkt(i, 0, 2, 2);
        push_exp(0, 0, 2); push_exp(1, 0, 2); push_exp(2, 0, 2);
        push_exp(3, 0, 2); push_exp(0, 2, 2);
        drive_inputs();
        drain(60, "t2");
        chk("t2_nready", 64'(d_nready), 64'd10);
        chk("t2_span",   64'(d_last - d_first + 1), 64'd14);

        // MAX_HOLD forces rotation away from a streaming requester
        do_reset();
        push_pkt(1, 0, 20, 0);
        push_pkt(2, 0, 2, 2);
        push_exp(1, 0, 8); push_exp(2, 0, 2); push_exp(1, 8, 8); push_exp(1, 16, 4);
        drive_inputs();
        drain(80, "t3");
        chk("t3_nready", 64'(d_nready), 64'd22);
        chk("t3_span",   64'(d_last - d_first + 1), 64'd25);

        // Slave stall on the second word
        do_reset();
        push_pkt(0, 0, 4, 4);
        push_exp(0, 0, 4);
        drive_inputs();
        step();
        step();
        step();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_stall_write", 64'(s_write), 64'd1);
            chk("t4_stall_addr",  64'(s_addr),  64'(mk(0, 1, 1'b0).addr));
            chk("t4_stall_data",  64'(s_data),  64'(mk(0, 1, 1'b0).data));
            chk("t4_stall_ready", 64'(s_ready), 64'd0);
        end
        avm_waitrequest = 1'b0;
        step();
        chk("t4_resume_ready", 64'(s_ready), 64'b0001);
        drain(30, "t4");

        // Owner abandons the grant while its word is stalled
        do_reset();
        push_pkt(0, 0, 3, 0);
        push_exp(0, 0, 1);
        drive_inputs();
        step();
        step();
        chk("t5_first_ready", 64'(s_ready), 64'b0001);
        src_q.delete();
        drive_inputs();
        avm_waitrequest = 1'b1;
        step();
        chk("t5_abandon_ready", 64'(s_ready), 64'd0);
        step();
        chk("t5_pending_write", 64'(s_write), 64'd1);
        avm_waitrequest = 1'b0;
        step();
        step();
        chk("t5_write_done", 64'(s_write), 64'd0);
        chk("t5_busy_idle",  64'(s_busy),  64'd0);
        chk("t5_exp_empty",  64'(exp_q.size()), 64'd0);

        // Asynchronous reset with a stalled word in flight
        do_reset();
        avm_waitrequest = 1'b1;
        push_pkt(0, 0, 2, 2);
        drive_inputs();
        step();
        step();
        chk("t6_inflight", 64'(avm_write), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_write", 64'(avm_write), 64'd0);
        chk("t6_async_ready", 64'(req_ready), 64'd0);
        chk("t6_async_grant", 64'(grant_id),  64'(NUM_REQ - 1));
        chk("t6_async_busy",  64'(busy),      64'd0);
        chk("t6_async_addr",  64'(avm_address), 64'd0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
